openram_march_bist: RTL and testbench

//  March C- built-in self test for one OpenRAM RW port (port 0).

---
 rtl/openram_march_bist.sv | 215 +++++++++++++++++++++
 tb/tb_openram_march_bist.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/openram_march_bist.sv
// March C- built-in self test for OpenRAM port 0. It is transparent while idle.
// While running it owns the port and reports pass/fail and the first failing address/element.
module openram_march_bist #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  bist_start_i,
    output logic                  bist_busy_o,
    output logic                  bist_done_o,
    output logic                  bist_pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    input  logic                  up_csb0_i,
    input  logic                  up_web0_i,
    input  logic [3:0]            up_wmask0_i,
    input  logic [ADDR_WIDTH-1:0] up_addr0_i,
    input  logic [DATA_WIDTH-1:0] up_dout0_i,
    output logic [DATA_WIDTH-1:0] up_din0_o,
    output logic                  ram_clk0,
    output logic                  ram_csb0,
    output logic                  ram_web0,
    output logic [3:0]            ram_wmask0,
    output logic [ADDR_WIDTH-1:0] ram_addr0,
    output logic [DATA_WIDTH-1:0] ram_dout0,
    input  logic [DATA_WIDTH-1:0] ram_din0
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // E0 and E5 have a single op per address; the others have two.
    function automatic logic is_last_op(input logic [2:0] e, input logic op);
        return ((e == 3'd0) || (e == 3'd5)) ? 1'b1 : op;
    endfunction

    function automatic logic is_write(input logic [2:0] e, input logic op);
        return (e == 3'd0) || op;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wr_pattern(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? {DATA_WIDTH{1'b1}} : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_expect(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? {DATA_WIDTH{1'b1}} : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return is_down(e) ? ADDR_TOP : '0;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] last_addr(input logic [2:0] e);
        return is_down(e) ? '0 : ADDR_TOP;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_q, op_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [2:0]            felem_q, felem_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
    logic [DATA_WIDTH-1:0] cdata_q, cdata_d;
    logic                  step;
    logic                  finish;

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        faddr_d = faddr_q;
        felem_d = felem_q;
        step    = 1'b0;
        finish  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bist_start_i) begin
                    state_d = S_WR;
                    elem_d  = '0;
                    addr_d  = '0;
                    op_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    faddr_d = '0;
                    felem_d = '0;
                end
            end
            S_WR:  step = 1'b1;
            S_RD:  state_d = S_CMP;
            S_CMP: begin
                if (ram_din0 != rd_expect(elem_q)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    faddr_d = addr_q;
                    felem_d = elem_q;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Advance to the next op: second op at this address, next address, or next element.
        if (step) begin
            if (!is_last_op(elem_q, op_q)) begin
                op_d = 1'b1;
            end else begin
                op_d = 1'b0;
                if (addr_q == last_addr(elem_q)) begin
                    if (elem_q == 3'd5) begin
                        finish = 1'b1;
                    end else begin
                        elem_d = elem_q + 3'd1;
                        addr_d = first_addr(elem_q + 3'd1);
                    end
                end else begin
                    addr_d = is_down(elem_q) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                end
            end
            if (finish) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end else begin
                state_d = is_write(elem_d, op_d) ? S_WR : S_RD;
            end
        end

        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'hF;
        caddr_d = caddr_q;
        cdata_d = cdata_q;
        if (state_d == S_WR) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            caddr_d = addr_d;
            cdata_d = wr_pattern(elem_d);
        end else if (state_d == S_RD) begin
            csb_d   = 1'b0;
            caddr_d = addr_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            faddr_q <= '0;
            felem_q <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'hF;
            caddr_q <= '0;
            cdata_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            faddr_q <= faddr_d;
            felem_q <= felem_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            caddr_q <= caddr_d;
            cdata_q <= cdata_d;
        end
    end

    // busy_q alone selects the port owner, so reset returns the port to pass-through at once.
    assign ram_clk0    = wb_clk_i;
    assign ram_csb0    = busy_q ? csb_q   : up_csb0_i;
    assign ram_web0    = busy_q ? web_q   : up_web0_i;
    assign ram_wmask0  = busy_q ? wmask_q : up_wmask0_i;
    assign ram_addr0   = busy_q ? caddr_q : up_addr0_i;
    assign ram_dout0   = busy_q ? cdata_q : up_dout0_i;
    assign up_din0_o   = ram_din0;

    assign bist_busy_o = busy_q;
    assign bist_done_o = done_q;
    assign bist_pass_o = pass_q;
    assign fail_addr_o = faddr_q;
    assign fail_elem_o = felem_q;
endmodule

// File: tb/tb_openram_march_bist.sv
// Bench for openram_march_bist: behavioural SRAM with optional faults, plus a March C- reference
// that predicts the per-cycle port trace and the final verdict.
`timescale 1ns/1ps
module tb_openram_march_bist;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 1 << AW;
    // March C- elements, up to two ops each: 0 none, 1 w0, 2 w1, 3 r0, 4 r1
    localparam int MARCH [6][2] = '{'{1, 0}, '{3, 2}, '{4, 1}, '{3, 2}, '{4, 1}, '{3, 0}};

    typedef struct packed {
        logic          csb;
        logic          web;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          up_csb, up_web;
    logic [3:0]    up_wmask;
    logic [AW-1:0] up_addr;
    logic [DW-1:0] up_dout;
    logic [DW-1:0] up_din;
    logic          ram_clk0, ram_csb0, ram_web0;
    logic [3:0]    ram_wmask0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_dout0;
    logic [DW-1:0] ram_din0 = '0;

    int            n_checks = 0;
    int            n_err = 0;
    int            fault_mode = 0;
    int            ram_acc = 0;
    bit            mon_en = 1'b0;
    int            exp_idx = 0;
    int            busy_cnt = 0;
    cyc_t          exp_q[$];
    cyc_t          mon_c;
    bit            mon_ok;
    bit            exp_pass;
    logic [AW-1:0] exp_faddr;
    logic [2:0]    exp_felem;
    logic [DW-1:0] mem [N];
    int            acc_snap;

    always #5 clk = ~clk;

    openram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bist_start_i(start),
        .bist_busy_o(busy), .bist_done_o(done), .bist_pass_o(pass),
        .fail_addr_o(fail_addr), .fail_elem_o(fail_elem),
        .up_csb0_i(up_csb), .up_web0_i(up_web), .up_wmask0_i(up_wmask),
        .up_addr0_i(up_addr), .up_dout0_i(up_dout), .up_din0_o(up_din),
        .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
        .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_dout0(ram_dout0),
        .ram_din0(ram_din0)
    );

    // Fault 1: bit 3 of address 5 stuck at 1. Fault 2: writing ones to 0x2 clears 0x3.
    function automatic logic [DW-1:0] faulty_read(input int fm, input logic [AW-1:0] a,
                                                  input logic [DW-1:0] v);
        if (fm == 1 && a == 4'h5) return v | 32'h8;
        return v;
    endfunction

    function automatic bit coupled(input int fm, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return (fm == 2) && (a == 4'h2) && (d == {DW{1'b1}});
    endfunction

    always @(posedge clk) begin
        if (!ram_csb0) begin
            ram_acc <= ram_acc + 1;
            if (!ram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask0[b]) mem[ram_addr0][b*8 +: 8] <= ram_dout0[b*8 +: 8];
                if (coupled(fault_mode, ram_addr0, ram_dout0)) mem[3] <= '0;
            end else begin
                ram_din0 <= faulty_read(fault_mode, ram_addr0, mem[ram_addr0]);
            end
        end
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Walk the March C- table over an ideal (or faulty) memory array; emit one entry per port cycle.
    task automatic build_model(input int fm);
        logic [DW-1:0] m [N];
        logic [DW-1:0] v;
        cyc_t          c;
        bit            stop;
        int            a;
        int            code;
        exp_q.delete();
        exp_pass  = 1'b1;
        exp_faddr = '0;
        exp_felem = '0;
        stop      = 1'b0;
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int k = 0; k < N && !stop; k++) begin
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                for (int o = 0; o < 2 && !stop; o++) begin
                    code = MARCH[e][o];
                    if (code == 1 || code == 2) begin
                        v = (code == 2) ? {DW{1'b1}} : '0;
                        c.csb = 1'b0; c.web = 1'b0; c.addr = a[AW-1:0]; c.data = v;
                        exp_q.push_back(c);
                        m[a] = v;
                        if (coupled(fm, a[AW-1:0], v)) m[3] = '0;
                    end else if (code >= 3) begin
                        v = (code == 4) ? {DW{1'b1}} : '0;
                        c.csb = 1'b0; c.web = 1'b1; c.addr = a[AW-1:0]; c.data = '0;
                        exp_q.push_back(c);
                        c.csb = 1'b1;
                        exp_q.push_back(c);
                        if (faulty_read(fm, a[AW-1:0], m[a]) != v) begin
                            exp_pass  = 1'b0;
                            exp_faddr = a[AW-1:0];
                            exp_felem = e[2:0];
                            stop      = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && busy) begin
            busy_cnt++;
            if (exp_idx >= exp_q.size()) begin
                chk(1'b0, "trace_overrun", 64'(busy_cnt), 64'(exp_q.size()));
            end else begin
                mon_c = exp_q[exp_idx];
                exp_idx++;
                mon_ok = (ram_csb0 == mon_c.csb);
                if (!mon_c.csb)
                    mon_ok = mon_ok && ram_web0 == mon_c.web && ram_addr0 == mon_c.addr
                             && ram_wmask0 == 4'hF;
                if (!mon_c.csb && !mon_c.web) mon_ok = mon_ok && ram_dout0 == mon_c.data;
                chk(mon_ok, "trace", {ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_dout0},
                    {mon_c.csb, mon_c.web, 4'hF, mon_c.addr, mon_c.data});
            end
        end
    end

    task automatic start_run(input int fm);
        fault_mode = fm;
        build_model(fm);
        exp_idx  = 0;
        busy_cnt = 0;
        mon_en   = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(busy == 1'b1, "start_busy", 64'(busy), 64'd1);
        chk(done == 1'b0, "start_done_clr", 64'(done), 64'd0);
        chk(pass == 1'b0, "start_pass_clr", 64'(pass), 64'd0);
    endtask

    task automatic finish_run(input bit poke);
        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk); #1;
            start = (poke && i == 50);
        end
        start = 1'b0;
        chk(done == 1'b1, "done_timeout", 64'(done), 64'd1);
        chk(busy_cnt == exp_q.size(), "busy_cycles", 64'(busy_cnt), 64'(exp_q.size()));
        chk(exp_idx == exp_q.size(), "trace_len", 64'(exp_idx), 64'(exp_q.size()));
        chk(pass == exp_pass, "pass", 64'(pass), 64'(exp_pass));
        if (!exp_pass) begin
            chk(fail_addr == exp_faddr, "fail_addr", 64'(fail_addr), 64'(exp_faddr));
            chk(fail_elem == exp_felem, "fail_elem", 64'(fail_elem), 64'(exp_felem));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        up_csb = 1'b1; up_web = 1'b1; up_wmask = 4'hF; up_addr = '0; up_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
        chk({done, pass} == 2'b00, "rst_done_pass", 64'({done, pass}), 64'd0);
        chk({fail_addr, fail_elem} == '0, "rst_fail", 64'({fail_addr, fail_elem}), 64'd0);
        chk(ram_csb0 == 1'b1, "rst_csb", 64'(ram_csb0), 64'd1);
        rst_n = 1'b1;

        // Pass-through: write then read back through the wrapper port.
        up_csb = 1'b0; up_web = 1'b0; up_addr = 4'hC; up_dout = 32'hA5A5_5A5A;
        #1;
        chk({ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_dout0} == {1'b0, 1'b0, 4'hF, 4'hC, 32'hA5A5_5A5A},
            "thru_wr", {ram_csb0, ram_web0, ram_wmask0, ram_addr0, ram_dout0}, {1'b0, 1'b0, 4'hF, 4'hC, 32'hA5A5_5A5A});
        chk(ram_clk0 == clk, "ram_clk", 64'(ram_clk0), 64'(clk));
        @(posedge clk); #1;
        up_web = 1'b1; up_wmask = 4'h3; up_addr = 4'hC; up_dout = 32'h0123_4567;
        #1;
        chk({ram_web0, ram_wmask0, ram_addr0, ram_dout0} == {1'b1, 4'h3, 4'hC, 32'h0123_4567},
            "thru_rd", {ram_web0, ram_wmask0, ram_addr0, ram_dout0}, {1'b1, 4'h3, 4'hC, 32'h0123_4567});
        @(posedge clk); #1;
        chk(up_din == 32'hA5A5_5A5A, "thru_din", 64'(up_din), 64'hA5A5_5A5A);
        chk(up_din == ram_din0, "din_mirror", 64'(up_din), 64'(ram_din0));
        up_csb = 1'b1; up_wmask = 4'hF; up_addr = '0; up_dout = '0;

        // Clean run with a start pulse while busy.
        start_run(0);
        chk(exp_q.size() == 240, "model_len", 64'(exp_q.size()), 64'd240);
        finish_run(1'b1);
        chk(pass == 1'b1, "clean_pass", 64'(pass), 64'd1);
        chk(busy_cnt == 240, "clean_240", 64'(busy_cnt), 64'd240);

        // Restart straight from DONE.
        start_run(0);
        finish_run(1'b0);
        chk(busy_cnt == 240, "rerun_240", 64'(busy_cnt), 64'd240);

        // Stuck-at-1 bit 3 at 0x5.
        start_run(1);
        chk({exp_pass, exp_faddr, exp_felem} == {1'b0, 4'h5, 3'd1}, "model_stuck",
            64'({exp_pass, exp_faddr, exp_felem}), 64'({1'b0, 4'h5, 3'd1}));
        finish_run(1'b0);
        chk({pass, fail_addr, fail_elem} == {1'b0, 4'h5, 3'd1}, "stuck_result",
            64'({pass, fail_addr, fail_elem}), 64'({1'b0, 4'h5, 3'd1}));
        acc_snap = ram_acc;
        repeat (5) @(posedge clk);
        #1;
        chk(ram_acc == acc_snap, "no_access_after_fail", 64'(ram_acc), 64'(acc_snap));
        chk({done, pass, fail_addr} == {1'b1, 1'b0, 4'h5}, "sticky",
            64'({done, pass, fail_addr}), 64'({1'b1, 1'b0, 4'h5}));

        // Coupling fault only visible in the descending elements.
        start_run(2);
        chk({exp_pass, exp_faddr, exp_felem} == {1'b0, 4'h3, 3'd4}, "model_coupling",
            64'({exp_pass, exp_faddr, exp_felem}), 64'({1'b0, 4'h3, 3'd4}));
        finish_run(1'b0);
        chk({pass, fail_addr, fail_elem} == {1'b0, 4'h3, 3'd4}, "coupling_result",
            64'({pass, fail_addr, fail_elem}), 64'({1'b0, 4'h3, 3'd4}));

        // Asynchronous reset in the middle of E2.
        start_run(0);
        repeat (80) @(posedge clk);
        #1;
        chk(exp_idx > 64 && exp_idx < 112, "in_e2", 64'(exp_idx), 64'd80);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk(busy == 1'b0, "midrst_busy", 64'(busy), 64'd0);
        chk({done, pass, fail_addr, fail_elem} == '0, "midrst_flags",
            64'({done, pass, fail_addr, fail_elem}), 64'd0);
        chk(ram_csb0 == up_csb, "midrst_csb1", 64'(ram_csb0), 64'(up_csb));
        up_csb = 1'b0; up_addr = 4'h9;
        #1;
        chk({ram_csb0, ram_addr0} == {1'b0, 4'h9}, "midrst_csb0", 64'({ram_csb0, ram_addr0}), 64'({1'b0, 4'h9}));
        up_csb = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk(busy == 1'b0, "after_rst_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
